// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the three-way ALU sharing arbiter.
// Holds the FSM state encoding, ALU opcode values and modulo-3 pointer helpers.
package alu_share_arb_pkg;

    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;

    // (base + step) mod 3 for requester indices
    function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            wrap3 = 2'(sum - 3'd3);
        end else begin
            wrap3 = sum[1:0];
        end
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] id);
        rr_next = wrap3(id, 2'd1);
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arb3.sv
// Combinational three-way round-robin picker: first requester at or after ptr wins.
module rr_arb3
    import alu_share_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic [1:0] gnt_id
);

    logic [1:0] ptr_s;
    logic [1:0] idx_s;
    logic       found_s;

    // An out-of-range pointer value behaves like pointer 0
    assign ptr_s = (ptr == 2'd3) ? 2'd0 : ptr;

    // Scan ptr, ptr+1, ptr+2 and grant the first active request
    always_comb begin
        gnt     = 3'b000;
        gnt_id  = 2'd0;
        idx_s   = 2'd0;
        found_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx_s = wrap3(ptr_s, 2'(k));
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among three requesters: round-robin accept, hold operands for
// ALU_LAT cycles, then present the captured result until the consumer takes it.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int W       = 8,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [OPW-1:0]      alu_op,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    input  logic [W-1:0]        alu_y,
    input  logic                alu_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_id,
    output logic [W-1:0]        rsp_y,
    output logic                rsp_cout,
    output logic                busy
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_e         state_q, state_d;
    logic [1:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     id_q, id_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [1:0]     rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_y_q, rsp_y_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic [2:0]     gnt_s;
    logic [1:0]     gnt_id_s;
    logic [2:0]     ready_s;

    rr_arb3 u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    // Next-state and datapath capture for the IDLE -> EXEC -> RESP cycle
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_cout_d  = rsp_cout_q;
        ready_s     = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (req_valid != 3'b000) begin
                    ready_s  = gnt_s;
                    alu_op_d = req_op[int'(gnt_id_s)*OPW +: OPW];
                    alu_a_d  = req_a[int'(gnt_id_s)*W +: W];
                    alu_b_d  = req_b[int'(gnt_id_s)*W +: W];
                    id_d     = gnt_id_s;
                    rr_ptr_d = rr_next(gnt_id_s);
                    cnt_d    = CNT_INIT;
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_y_d     = alu_y;
                    rsp_cout_d  = alu_cout;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and operand/result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'd0;
            cnt_q       <= 4'd0;
            id_q        <= 2'd0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
            rsp_y_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    // Grant is suppressed while reset is held so nothing looks accepted
    assign req_ready = rst ? 3'b000 : ready_s;
    assign busy      = (state_q != ST_IDLE);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized self-checking bench for alu_share_arb with a settling ALU model;
// a second instance runs with ALU_LAT=1.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int W = 8;
    localparam int OPW = 3;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic [2:0] req_valid;
    logic [3*OPW-1:0] req_op;
    logic [3*W-1:0] req_a, req_b;
    logic rsp_ready;

    logic [2:0] rv0, rr0, rv1, rr1;
    logic [2:0] aop0, aop1;
    logic [7:0] aa0, ab0, ay0, ry0, aa1, ab1, ay1, ry1;
    logic ac0, rsv0, rc0, busy0, ac1, rsv1, rc1, busy1;
    logic [1:0] rid0, rid1;

    logic [2:0] o_ready;
    logic o_rsp_valid, o_rsp_cout, o_busy;
    logic [1:0] o_rsp_id;
    logic [7:0] o_rsp_y;

    int total = 0;
    int bad = 0;
    int mptr[2];
    int ng, nr;
    int g_id[8], g_cyc[8], r_id[8];
    logic [7:0] r_y[8];
    logic r_c[8];

    always #5 clk = ~clk;

    assign rv0 = sel ? 3'b000 : req_valid;
    assign rv1 = sel ? req_valid : 3'b000;
    assign o_ready     = sel ? rr1 : rr0;
    assign o_rsp_valid = sel ? rsv1 : rsv0;
    assign o_rsp_id    = sel ? rid1 : rid0;
    assign o_rsp_y     = sel ? ry1 : ry0;
    assign o_rsp_cout  = sel ? rc1 : rc0;
    assign o_busy      = sel ? busy1 : busy0;

    alu_share_arb #(.W(8), .OPW(3), .ALU_LAT(2)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(aop0), .alu_a(aa0), .alu_b(ab0), .alu_y(ay0), .alu_cout(ac0),
        .rsp_valid(rsv0), .rsp_ready(rsp_ready), .rsp_id(rid0), .rsp_y(ry0),
        .rsp_cout(rc0), .busy(busy0)
    );

    alu_share_arb #(.W(8), .OPW(3), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(aop1), .alu_a(aa1), .alu_b(ab1), .alu_y(ay1), .alu_cout(ac1),
        .rsp_valid(rsv1), .rsp_ready(rsp_ready), .rsp_id(rid1), .rsp_y(ry1),
        .rsp_cout(rc1), .busy(busy1)
    );

    function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_AND:  alu_ref = {1'b0, a & b};
            OP_OR:   alu_ref = {1'b0, a | b};
            OP_NOR:  alu_ref = {1'b0, ~(a | b)};
            OP_ADD:  alu_ref = {1'b0, a} + {1'b0, b};
            OP_XOR:  alu_ref = {1'b0, a ^ b};
            default: alu_ref = {1'b0, a};
        endcase
    endfunction

    // ALU model for the 2-cycle instance: output is garbage until inputs have
    // been stable across one falling edge, i.e. valid only at the ALU_LAT-th edge.
    logic [18:0] last0;
    int stab0 = 0;
    always @(negedge clk) begin
        if ({aop0, aa0, ab0} !== last0) begin
            last0 <= {aop0, aa0, ab0};
            stab0 <= 0;
        end else if (stab0 < 15) begin
            stab0 <= stab0 + 1;
        end
    end
    assign {ac0, ay0} = (stab0 >= 1) ? alu_ref(aop0, aa0, ab0) : 9'h15A;
    assign {ac1, ay1} = alu_ref(aop1, aa1, ab1);

    function automatic int pick(input logic [2:0] mask, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (mask[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [2:0] oh);
        case (oh)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [8:0] exp_for(input int w);
        return alu_ref(req_op[w*OPW +: OPW], req_a[w*W +: W], req_b[w*W +: W]);
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 3; i++) begin
            req_op[i*OPW +: OPW] = 3'($urandom_range(0, 5));
            req_a[i*W +: W] = 8'($urandom);
            req_b[i*W +: W] = 8'($urandom);
        end
    endtask

    // One transaction from a negedge; returns grant seen and response observed.
    task automatic issue(input logic [2:0] mask, input bit hold_resp, output logic [2:0] rdy,
                         output int lat, output logic [1:0] id, output logic [7:0] y, output logic c);
        req_valid = mask;
        #1 rdy = o_ready;
        @(posedge clk);
        #1 req_valid = 3'b000;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (o_rsp_valid) begin
                lat = k;
                break;
            end
        end
        id = o_rsp_id;
        y = o_rsp_y;
        c = o_rsp_cout;
        if (!hold_resp) @(posedge clk);
        @(negedge clk);
    endtask

    // Hold a request mask until n grants are seen, logging grants and responses.
    task automatic collect(input logic [2:0] mask, input int n);
        ng = 0;
        nr = 0;
        req_valid = mask;
        for (int cyc = 0; cyc < 80 && (ng < n || nr < n); cyc++) begin
            #1;
            if (o_ready != 3'b000 && ng < 8) begin
                g_id[ng] = oh_idx(o_ready);
                g_cyc[ng] = cyc;
                ng++;
            end
            if (o_rsp_valid && nr < 8) begin
                r_id[nr] = int'(o_rsp_id);
                r_y[nr] = o_rsp_y;
                r_c[nr] = o_rsp_cout;
                nr++;
            end
            @(posedge clk);
            #1;
            if (ng >= n) req_valid = 3'b000;
            @(negedge clk);
        end
        req_valid = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        #1;
        total++;
        if (o_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", o_ready); end
        total++;
        if ({busy0, rsv0, rid0, ry0, rc0} !== 13'd0) begin
            bad++; $display("FAIL reset_rsp: got %h want 0", {busy0, rsv0, rid0, ry0, rc0});
        end
        total++;
        if ({aop0, aa0, ab0} !== 19'd0) begin bad++; $display("FAIL reset_alu: got %h want 0", {aop0, aa0, ab0}); end
        req_valid = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        mptr[0] = 0;
        mptr[1] = 0;
        @(negedge clk);
    endtask

    task automatic test_rr_all();
        int w;
        logic [8:0] e;
        rand_ops();
        rsp_ready = 1'b1;
        collect(3'b111, 6);
        total++;
        if (ng != 6 || nr != 6) begin bad++; $display("FAIL rr_count: got g=%0d r=%0d want 6/6", ng, nr); end
        for (int g = 0; g < 6 && g < ng && g < nr; g++) begin
            w = pick(3'b111, mptr[0]);
            mptr[0] = (w + 1) % 3;
            e = exp_for(w);
            total++;
            if (g_id[g] != w || r_id[g] != w) begin
                bad++; $display("FAIL rr_order[%0d]: got grant %0d rsp %0d want %0d", g, g_id[g], r_id[g], w);
            end
            total++;
            if ({r_c[g], r_y[g]} !== e) begin
                bad++; $display("FAIL rr_result[%0d]: got %h want %h", g, {r_c[g], r_y[g]}, e);
            end
            if (g > 0) begin
                total++;
                if (g_cyc[g] - g_cyc[g-1] != 4) begin
                    bad++; $display("FAIL rr_period[%0d]: got %0d want 4", g, g_cyc[g] - g_cyc[g-1]);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] rdy;
        int lat;
        logic [1:0] id;
        logic [7:0] y;
        logic c;
        rand_ops();
        req_op[1*OPW +: OPW] = OP_ADD;
        req_a[1*W +: W] = 8'h05;
        req_b[1*W +: W] = 8'h03;
        rsp_ready = 1'b1;
        issue(3'b010, 1'b0, rdy, lat, id, y, c);
        mptr[0] = (pick(3'b010, mptr[0]) + 1) % 3;
        total++;
        if (rdy !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", rdy); end
        total++;
        if (lat != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", lat); end
        total++;
        if ({id, c, y} !== {2'd1, 1'b0, 8'h08}) begin
            bad++; $display("FAIL single_rsp: got id=%0d c=%b y=%h want id=1 c=0 y=08", id, c, y);
        end
    endtask

    task automatic test_skip();
        logic [2:0] rdy;
        int lat, w;
        logic [1:0] id;
        logic [7:0] y;
        logic c;
        logic [2:0] masks[3];
        logic [2:0] want_oh[3];
        masks = '{3'b100, 3'b011, 3'b011};
        want_oh = '{3'b100, 3'b001, 3'b010};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            w = pick(masks[i], mptr[0]);
            mptr[0] = (w + 1) % 3;
            issue(masks[i], 1'b0, rdy, lat, id, y, c);
            total++;
            if (rdy !== want_oh[i] || rdy !== (3'b001 << w)) begin
                bad++; $display("FAIL skip_grant[%0d]: got %b want %b", i, rdy, want_oh[i]);
            end
            total++;
            if (int'(id) != w || {c, y} !== exp_for(w)) begin
                bad++; $display("FAIL skip_rsp[%0d]: got id=%0d %h want id=%0d %h", i, id, {c, y}, w, exp_for(w));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] rdy;
        int lat, w;
        logic [1:0] id;
        logic [7:0] y;
        logic c;
        logic [2:0] mask;
        rand_ops();
        mask = 3'($urandom_range(1, 7));
        w = pick(mask, mptr[0]);
        mptr[0] = (w + 1) % 3;
        rsp_ready = 1'b0;
        issue(mask, 1'b1, rdy, lat, id, y, c);
        total++;
        if (lat != 2 || int'(id) != w || {c, y} !== exp_for(w)) begin
            bad++; $display("FAIL bp_rsp: got lat=%0d id=%0d %h want lat=2 id=%0d %h", lat, id, {c, y}, w, exp_for(w));
        end
        req_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({o_rsp_valid, o_rsp_id, o_rsp_cout, o_rsp_y} !== {1'b1, id, c, y}) begin
                bad++; $display("FAIL bp_hold[%0d]: got %h want %h", i,
                                {o_rsp_valid, o_rsp_id, o_rsp_cout, o_rsp_y}, {1'b1, id, c, y});
            end
            total++;
            if (o_ready !== 3'b000 || o_busy !== 1'b1) begin
                bad++; $display("FAIL bp_ready_busy[%0d]: got ready=%b busy=%b want 000/1", i, o_ready, o_busy);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (o_ready !== 3'b000) begin bad++; $display("FAIL bp_release_ready: got %b want 000", o_ready); end
        @(posedge clk);
        #1 req_valid = 3'b000;
        total++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL bp_release: got valid=%b busy=%b want 0/0", o_rsp_valid, o_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [2:0] rdy;
        int lat;
        logic [1:0] id;
        logic [7:0] y;
        logic c;
        rand_ops();
        rsp_ready = 1'b1;
        req_valid = 3'b010;
        @(posedge clk);
        #1 req_valid = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({rr0, busy0, rsv0, rid0, ry0, rc0, aop0, aa0, ab0} !== 35'd0) begin
            bad++; $display("FAIL mid_reset_outputs: got %h want 0", {rr0, busy0, rsv0, rid0, ry0, rc0, aop0, aa0, ab0});
        end
        @(negedge clk);
        rst = 1'b0;
        mptr[0] = 0;
        mptr[1] = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (rsv0 !== 1'b0) begin bad++; $display("FAIL mid_reset_noresp[%0d]: got 1 want 0", i); end
            @(negedge clk);
        end
        rand_ops();
        issue(3'b111, 1'b0, rdy, lat, id, y, c);
        mptr[0] = 1;
        total++;
        if (rdy !== 3'b001 || id !== 2'd0 || {c, y} !== exp_for(0)) begin
            bad++; $display("FAIL mid_reset_first: got rdy=%b id=%0d %h want 001 id=0 %h", rdy, id, {c, y}, exp_for(0));
        end
    endtask

    task automatic test_random();
        logic [2:0] rdy, mask;
        int lat, w;
        logic [1:0] id;
        logic [7:0] y;
        logic c;
        bit hold;
        for (int n = 0; n < 20; n++) begin
            rand_ops();
            mask = 3'($urandom_range(1, 7));
            hold = 1'($urandom_range(0, 1));
            w = pick(mask, mptr[0]);
            mptr[0] = (w + 1) % 3;
            rsp_ready = !hold;
            issue(mask, hold, rdy, lat, id, y, c);
            if (hold) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            total++;
            if (rdy !== (3'b001 << w) || lat != 2 || int'(id) != w || {c, y} !== exp_for(w)) begin
                bad++; $display("FAIL random[%0d]: got rdy=%b lat=%0d id=%0d %h want %b 2 %0d %h",
                                n, rdy, lat, id, {c, y}, 3'b001 << w, w, exp_for(w));
            end
        end
    endtask

    task automatic test_lat1();
        logic [2:0] rdy;
        int lat;
        logic [1:0] id;
        logic [7:0] y;
        logic c;
        sel = 1'b1;
        rsp_ready = 1'b1;
        rand_ops();
        req_op[0 +: OPW] = OP_ADD;
        req_a[0 +: W] = 8'hFF;
        req_b[0 +: W] = 8'h01;
        @(negedge clk);
        issue(3'b001, 1'b0, rdy, lat, id, y, c);
        mptr[1] = 1;
        total++;
        if (rdy !== 3'b001 || lat != 1 || {id, c, y} !== {2'd0, 1'b1, 8'h00}) begin
            bad++; $display("FAIL lat1_single: got rdy=%b lat=%0d id=%0d c=%b y=%h want 001 1 0 1 00", rdy, lat, id, c, y);
        end
        collect(3'b001, 3);
        total++;
        if (ng != 3 || nr != 3) begin bad++; $display("FAIL lat1_count: got g=%0d r=%0d want 3/3", ng, nr); end
        for (int g = 0; g < ng && g < nr; g++) begin
            total++;
            if (g_id[g] != 0 || r_id[g] != 0 || {r_c[g], r_y[g]} !== 9'h100) begin
                bad++; $display("FAIL lat1_rsp[%0d]: got g=%0d r=%0d %h want 0 0 100", g, g_id[g], r_id[g], {r_c[g], r_y[g]});
            end
            if (g > 0) begin
                total++;
                if (g_cyc[g] - g_cyc[g-1] != 3) begin
                    bad++; $display("FAIL lat1_period[%0d]: got %0d want 3", g, g_cyc[g] - g_cyc[g-1]);
                end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        req_valid = 3'b000;
        rsp_ready = 1'b1;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_rr_all();
        test_single();
        test_skip();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
